// File: rtl/lsm_step_scheduler.sv
// Longstaff-Schwartz backward-induction sequencer for one lane: walks steps
// N_STEPS-1..0, fetches beta per step and streams path indices to the datapath.
module lsm_step_scheduler #(
    parameter int N_STEPS = 64,
    parameter int N_PATHS = 1024,
    parameter int MAX_OUT = 8,
    parameter int LANE_ID = 0,
    localparam int SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
    localparam int PW = (N_PATHS > 1) ? $clog2(N_PATHS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          beta_req,
    input  logic          beta_ack,
    output logic          iss_valid,
    input  logic          iss_ready,
    output logic [SW-1:0] step_idx,
    output logic [PW-1:0] path_idx,
    input  logic          res_valid,
    output logic          res_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    lane_id_out
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(N_PATHS + 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BETA  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [SW-1:0] SLAST = SW'(N_STEPS - 1);
    localparam logic [PW-1:0] PLAST = PW'(N_PATHS - 1);
    localparam logic [OW-1:0] OMAX  = OW'(MAX_OUT);
    localparam logic [CW-1:0] NP    = CW'(N_PATHS);

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [PW-1:0] path_q, path_d;
    logic [OW-1:0] out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          iss_fire, ret_fire;
    logic [CW-1:0] cnt_inc;

    assign beta_req    = (state_q == S_BETA);
    assign iss_valid   = (state_q == S_ISSUE) && (out_q < OMAX);
    assign res_ready   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign err         = err_q;
    assign step_idx    = step_q;
    assign path_idx    = path_q;
    assign lane_id_out = 8'(LANE_ID);

    assign iss_fire = iss_valid && iss_ready;
    assign ret_fire = res_valid && res_ready;
    assign cnt_inc  = cnt_q + {{(CW-1){1'b0}}, ret_fire};

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        path_d  = path_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (res_valid && (state_q == S_IDLE || state_q == S_BETA))
            err_d = 1'b1;
        if (ret_fire && out_q == '0)
            err_d = 1'b1;
        if (cnt_inc > NP)
            err_d = 1'b1;

        // Concurrent issue and return cancel; never underflow on a stray return.
        unique case ({iss_fire, ret_fire})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = (out_q != '0) ? out_q - 1'b1 : out_q;
            default: out_d = out_q;
        endcase
        if (ret_fire && cnt_q <= NP)
            cnt_d = cnt_inc;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    step_d  = SLAST;
                    state_d = S_BETA;
                end
            end
            S_BETA: begin
                if (beta_ack) begin
                    path_d  = '0;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (iss_fire) begin
                    if (path_q == PLAST)
                        state_d = S_DRAIN;
                    else
                        path_d = path_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_inc >= NP) begin
                    if (step_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        step_d  = step_q - 1'b1;
                        state_d = S_BETA;
                    end
                end
            end
            S_FIN: begin
                step_d  = '0;
                path_d  = '0;
                out_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            step_d  = '0;
            path_d  = '0;
            out_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            path_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            path_q  <= path_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsm_step_scheduler.sv
// Bench for lsm_step_scheduler: two lanes (wide window / tight window) driven
// by a latency model, with issue order scored against an expected queue.
module tb_lsm_step_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_start = 0, a_abort = 0, a_beta_ack = 0;
    logic       a_iss_ready = 1, a_res_valid = 0;
    logic       a_beta_req, a_iss_valid, a_res_ready;
    logic       a_busy, a_done, a_err;
    logic [0:0] a_step;
    logic [1:0] a_path;
    logic [7:0] a_lane;

    logic       b_start = 0, b_abort = 0, b_beta_ack = 0;
    logic       b_iss_ready = 1, b_res_valid = 0;
    logic       b_beta_req, b_iss_valid, b_res_ready;
    logic       b_busy, b_done, b_err;
    logic [0:0] b_step;
    logic [3:0] b_path;
    logic [7:0] b_lane;

    lsm_step_scheduler #(
        .N_STEPS(2), .N_PATHS(4), .MAX_OUT(8), .LANE_ID(5)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .beta_req(a_beta_req), .beta_ack(a_beta_ack),
        .iss_valid(a_iss_valid), .iss_ready(a_iss_ready),
        .step_idx(a_step), .path_idx(a_path),
        .res_valid(a_res_valid), .res_ready(a_res_ready),
        .busy(a_busy), .done(a_done), .err(a_err), .lane_id_out(a_lane)
    );

    lsm_step_scheduler #(
        .N_STEPS(2), .N_PATHS(12), .MAX_OUT(2), .LANE_ID(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .beta_req(b_beta_req), .beta_ack(b_beta_ack),
        .iss_valid(b_iss_valid), .iss_ready(b_iss_ready),
        .step_idx(b_step), .path_idx(b_path),
        .res_valid(b_res_valid), .res_ready(b_res_ready),
        .busy(b_busy), .done(b_done), .err(b_err), .lane_id_out(b_lane)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    int exp_a[$], exp_b[$];
    int a_due[$], b_due[$];
    int a_lat = 3, b_lat = 3;
    bit a_hold = 0, b_hold = 0, a_force = 0;
    int b_rel = 0;
    bit b_mode = 0, bp_chk = 0;
    int a_bc = 0, b_bc = 0;
    int a_niss = 0, a_nret = 0, a_ndone = 0;
    int b_niss = 0, b_nret = 0, b_ndone = 0;
    bit b_last_i = 0, b_last_r = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_run(input bit lane_b, input int np);
        for (int s = 1; s >= 0; s--)
            for (int p = 0; p < np; p++)
                if (lane_b) exp_b.push_back(s * 256 + p);
                else        exp_a.push_back(s * 256 + p);
    endtask

    task automatic tick();
        bit ai, ar, bi, br, bstall;
        int at, bt, e;
        ai = a_iss_valid && a_iss_ready;
        ar = a_res_valid && a_res_ready;
        bi = b_iss_valid && b_iss_ready;
        br = b_res_valid && b_res_ready;
        bstall = b_iss_valid && !b_iss_ready;
        at = int'(a_step) * 256 + int'(a_path);
        bt = int'(b_step) * 256 + int'(b_path);
        @(posedge clk);
        #1;
        cyc++;
        if (ar) begin
            a_nret++;
            if (a_due.size() > 0) e = a_due.pop_front();
        end
        if (ai) begin
            a_niss++;
            if (exp_a.size() == 0) chk("a_extra_issue", at, -1);
            else chk("a_issue_order", at, exp_a.pop_front());
            a_due.push_back(cyc + a_lat - 1);
        end
        if (br) begin
            b_nret++;
            if (b_due.size() > 0) e = b_due.pop_front();
            if (b_rel > 0) b_rel--;
        end
        if (bi) begin
            b_niss++;
            if (exp_b.size() == 0) chk("b_extra_issue", bt, -1);
            else chk("b_issue_order", bt, exp_b.pop_front());
            b_due.push_back(cyc + b_lat - 1);
        end
        b_last_i = bi;
        b_last_r = br;
        if (bp_chk && bstall) begin
            chk("b_stall_path", int'(b_step) * 256 + int'(b_path), bt);
            chk("b_stall_valid", int'(b_iss_valid), 1);
        end
        if (a_done) a_ndone++;
        if (b_done) b_ndone++;
        a_res_valid = a_force ||
            (!a_hold && a_due.size() > 0 && a_due[0] <= cyc);
        b_res_valid = (b_due.size() > 0 && b_due[0] <= cyc) &&
            (!b_hold || b_rel > 0);
        a_bc = a_beta_req ? a_bc + 1 : 0;
        b_bc = b_beta_req ? b_bc + 1 : 0;
        a_beta_ack = a_beta_req && a_bc >= 2;
        b_beta_ack = b_beta_req && b_bc >= 2;
        a_iss_ready = 1'b1;
        b_iss_ready = b_mode ? !b_iss_ready : 1'b1;
    endtask

    task automatic pulse_start(input bit lane_b);
        if (lane_b) b_start = 1; else a_start = 1;
        tick();
        a_start = 0;
        b_start = 0;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_beta_req"}, int'(a_beta_req), 0);
        chk({tag, "_iss_valid"}, int'(a_iss_valid), 0);
        chk({tag, "_res_ready"}, int'(a_res_ready), 0);
        chk({tag, "_step"}, int'(a_step), 0);
        chk({tag, "_path"}, int'(a_path), 0);
        chk({tag, "_busy"}, int'(a_busy), 0);
        chk({tag, "_done"}, int'(a_done), 0);
        chk({tag, "_err"}, int'(a_err), 0);
    endtask

    initial begin
        int t;
        tick();
        tick();
        chk_a_zero("rst");
        chk("rst_b_busy", int'(b_busy), 0);
        chk("rst_lane_a", int'(a_lane), 5);
        chk("rst_lane_b", int'(b_lane), 0);
        rst_n = 1;
        tick();

        // basic two-step run on lane A
        push_run(0, 4);
        pulse_start(0);
        t = 0;
        while (a_ndone == 0 && t < 200) begin tick(); t++; end
        chk("a_done_seen", a_ndone, 1);
        chk("a_busy_in_fin", int'(a_busy), 1);
        tick();
        chk("a_busy_after_done", int'(a_busy), 0);
        chk("a_done_width", int'(a_done), 0);
        repeat (5) tick();
        chk("a_done_once", a_ndone, 1);
        chk("a_issues", a_niss, 8);
        chk("a_returns", a_nret, 8);
        chk("a_sb_empty", exp_a.size(), 0);
        chk("a_err_clean", int'(a_err), 0);

        // outstanding cap on lane B
        b_hold = 1;
        push_run(1, 12);
        pulse_start(1);
        repeat (12) tick();
        chk("b_cap_issues", b_niss, 2);
        chk("b_cap_valid", int'(b_iss_valid), 0);
        b_rel = 1;
        tick();
        tick();
        chk("b_rel_ret", b_nret, 1);
        chk("b_rel_pre", b_niss, 2);
        tick();
        chk("b_rel_one", b_niss, 3);
        repeat (4) tick();
        chk("b_rel_only", b_niss, 3);

        // backpressure for the rest of the run
        b_hold = 0;
        b_mode = 1;
        bp_chk = 1;
        t = 0;
        while (b_ndone == 0 && t < 500) begin tick(); t++; end
        bp_chk = 0;
        b_mode = 0;
        tick();
        chk("b_bp_done", b_ndone, 1);
        chk("b_bp_issues", b_niss, 24);
        chk("b_bp_sb_empty", exp_b.size(), 0);
        chk("b_bp_err", int'(b_err), 0);

        // issue and return in the same cycle
        b_lat = 1;
        b_niss = 0;
        b_nret = 0;
        b_ndone = 0;
        push_run(1, 12);
        pulse_start(1);
        t = 0;
        while (!b_last_i && t < 20) begin tick(); t++; end
        chk("b_sim_start", int'(b_last_i), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("b_sim_iss", int'(b_last_i), 1);
            chk("b_sim_ret", int'(b_last_r), 1);
        end
        t = 0;
        while (b_ndone == 0 && t < 200) begin tick(); t++; end
        chk("b_sim_done", b_ndone, 1);
        chk("b_sim_returns", b_nret, 24);
        chk("b_sim_err", int'(b_err), 0);

        // abort in the drain of the first step
        a_ndone = 0;
        for (int p = 0; p < 4; p++) exp_a.push_back(256 + p);
        pulse_start(0);
        t = 0;
        while (!(a_res_ready && !a_iss_valid && a_step == 1'b1) && t < 50) begin
            tick();
            t++;
        end
        chk("a_in_drain", int'(a_res_ready && !a_iss_valid), 1);
        chk("a_abort_cycle_busy", int'(a_busy), 1);
        a_hold = 1;
        a_abort = 1;
        tick();
        a_abort = 0;
        a_hold = 0;
        a_due.delete();
        chk("a_abort_idle", int'(a_busy), 0);
        repeat (3) tick();
        chk("a_abort_nodone", a_ndone, 0);
        chk("a_abort_err", int'(a_err), 0);
        push_run(0, 4);
        pulse_start(0);
        chk("a_restart_step", int'(a_step), 1);
        chk("a_restart_path", int'(a_path), 0);
        t = 0;
        while (a_ndone == 0 && t < 200) begin tick(); t++; end
        chk("a_restart_done", a_ndone, 1);
        chk("a_restart_sb", exp_a.size(), 0);

        // reset asserted mid-issue
        repeat (2) tick();
        a_lat = 20;
        push_run(0, 4);
        pulse_start(0);
        t = 0;
        while (!a_iss_valid && t < 20) begin tick(); t++; end
        tick();
        chk("a_mid_issue", int'(a_iss_valid), 1);
        rst_n = 0;
        #1;
        chk_a_zero("mid_rst");
        exp_a.delete();
        a_due.delete();
        a_res_valid = 0;
        a_beta_ack = 0;
        tick();
        rst_n = 1;
        tick();

        // stray result in IDLE sets sticky err
        a_force = 1;
        a_res_valid = 1;
        tick();
        a_force = 0;
        tick();
        chk("a_err_set", int'(a_err), 1);
        repeat (5) tick();
        chk("a_err_sticky", int'(a_err), 1);
        rst_n = 0;
        #1;
        chk("a_err_rst", int'(a_err), 0);
        tick();
        rst_n = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
